conf_register_loader: RTL and testbench

Receive side of the configuration-register path: deserializes RX_WIDTH-bit words arriving from the host interface into address + data write frames and commits them into the configuration register array. The full array drives the rest of the design and the configuration readback path as a flat 2D bus. Data is assembled LSB-chunk-first, matching the readback shift order.

---
 rtl/conf_register_loader.sv | 212 +++++++++++++++++++++
 tb/tb_conf_register_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_register_loader.sv
// ---------------------------------------------------------------------------
// conf_register_loader
//
// Receive side of the configuration-register path. RX_WIDTH-bit words from
// the host interface are grouped into frames and committed into the
// configuration register array. A frame is one address word followed by
// DATA_WIDTH/RX_WIDTH data words. Data words are placed least-significant
// chunk first, which matches the readback shift order.
//
// Optional feature macro: CONF_RX_TIMEOUT_EN
//   Defined   - a partially received frame is dropped after TIMEOUT_CYCLES
//               cycles without a transfer, and timeout pulses for one cycle.
//   Undefined - no timeout logic; timeout is held at 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_data    received word
//   rx_valid   rx_data valid
//   rx_ready   loader can accept (transfer = rx_valid & rx_ready at an edge)
//   registers  flat register array, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_strobe  one-cycle pulse when a register was written
//   wr_addr    index of the last committed or attempted register
//   addr_error one-cycle pulse when a frame addressed index >= NUM_REGS
//   timeout    one-cycle pulse when a frame was dropped by the timeout
// ---------------------------------------------------------------------------
module conf_register_loader #(
  parameter int NUM_REGS       = 20,
  parameter int DATA_WIDTH     = 16,
  parameter int RX_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RX_WIDTH-1:0]            rx_data,
  input  logic                           rx_valid,
  output logic                           rx_ready,
  output logic [DATA_WIDTH*NUM_REGS-1:0] registers,
  output logic                           wr_strobe,
  output logic [RX_WIDTH-1:0]            wr_addr,
  output logic                           addr_error,
  output logic                           timeout
);

  localparam int CHUNKS = DATA_WIDTH / RX_WIDTH;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
  localparam logic [CW-1:0] CHUNK_ONE  = CW'(1);
  // One extra bit so NUM_REGS == 2**RX_WIDTH is representable in the compare.
  localparam logic [RX_WIDTH:0] NUM_REGS_EXT = (RX_WIDTH + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [RX_WIDTH-1:0]   addr;
  logic [CW-1:0]         chunk;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic xfer;
  logic latch_addr;
  logic take_chunk;
  logic commit;
  logic bad_addr;
  logic to_hit;

  assign xfer = rx_valid & rx_ready;

`ifdef CONF_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [TW-1:0] to_cnt;

  // A transfer on the expiry cycle wins, so xfer masks the hit.
  assign to_hit = (state == ST_DATA) && !xfer && (to_cnt == TO_LAST);

  // Cycles since the last transfer while a frame is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if ((state != ST_DATA) || xfer || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_ONE;
    end
  end
`else
  // Timeout disabled: constant-false expression keeps the parameter referenced.
  assign to_hit = (TIMEOUT_CYCLES < 32'sd0);
`endif

  // Next-state and per-cycle control decode.
  always_comb begin
    next_state = state;
    latch_addr = 1'b0;
    take_chunk = 1'b0;
    commit     = 1'b0;
    bad_addr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          latch_addr = 1'b1;
          next_state = ST_DATA;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          take_chunk = 1'b1;
          if (chunk == LAST_CHUNK) begin
            next_state = ST_WRITE;
          end else begin
            next_state = ST_DATA;
          end
        end else if (to_hit) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_DATA;
        end
      end
      ST_WRITE: begin
        next_state = ST_IDLE;
        if ({1'b0, addr} < NUM_REGS_EXT) begin
          commit = 1'b1;
        end else begin
          bad_addr = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame assembly: address latch, chunk counter and data accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr  <= '0;
      chunk <= '0;
      acc   <= '0;
    end else if (latch_addr) begin
      addr  <= rx_data;
      chunk <= '0;
      acc   <= '0;
    end else if (take_chunk) begin
      for (int c = 0; c < CHUNKS; c++) begin
        if (chunk == CW'(c)) begin
          acc[c*RX_WIDTH +: RX_WIDTH] <= rx_data;
        end
      end
      chunk <= chunk + CHUNK_ONE;
    end
  end

  // Register array: only the addressed entry changes, and only on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && (addr == RX_WIDTH'(i))) begin
          regs[i] <= acc;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign registers[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  // Registered status outputs; rx_ready drops only for the write cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready   <= 1'b1;
      wr_strobe  <= 1'b0;
      addr_error <= 1'b0;
      timeout    <= 1'b0;
      wr_addr    <= '0;
    end else begin
      rx_ready   <= (next_state != ST_WRITE);
      wr_strobe  <= commit;
      addr_error <= bad_addr;
      timeout    <= to_hit;
      if (state == ST_WRITE) begin
        wr_addr <= addr;
      end else begin
        wr_addr <= wr_addr;
      end
    end
  end

endmodule

// File: tb/tb_conf_register_loader.sv
// ---------------------------------------------------------------------------
// tb_conf_register_loader
//
// Directed bench for conf_register_loader. A frame-level model (word queue
// plus register array) predicts every output each cycle; literal checks pin
// the expected results of each directed scenario.
// ---------------------------------------------------------------------------
module tb_conf_register_loader;

  localparam int NR = 20;
  localparam int DW = 16;
  localparam int RW = 8;
  localparam int CH = DW / RW;
  localparam int TO = 16;
`ifdef CONF_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [RW-1:0]     rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [DW*NR-1:0]  registers;
  logic              wr_strobe;
  logic [RW-1:0]     wr_addr;
  logic              addr_error;
  logic              timeout;

  always #5 clk = ~clk;

  conf_register_loader #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .RX_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .registers(registers), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .addr_error(addr_error), .timeout(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW*NR-1:0] act,
                       input logic [DW*NR-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [DW-1:0] m_regs [NR];
  logic [RW-1:0] frame [$];
  bit            pend;
  logic [RW-1:0] p_addr;
  logic [DW-1:0] p_data;
  bit            m_strobe, m_err, m_to;
  bit            m_ready = 1'b1;
  logic [RW-1:0] m_wraddr;
  int            idle;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;
      frame.delete();
      pend = 1'b0; m_strobe = 1'b0; m_err = 1'b0; m_to = 1'b0;
      m_ready = 1'b1; m_wraddr = 8'h00; idle = 0;
    end else begin
      m_strobe = 1'b0; m_err = 1'b0; m_to = 1'b0;
      if (pend) begin
        pend = 1'b0;
        m_wraddr = p_addr;
        if (int'(p_addr) < NR) begin
          m_regs[int'(p_addr)] = p_data;
          m_strobe = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end else if (rx_valid && m_ready) begin
        frame.push_back(rx_data);
        idle = 0;
        if (frame.size() == 1 + CH) begin
          p_addr = frame[0];
          p_data = 16'h0000;
          for (int k = 1; k <= CH; k++) p_data = p_data | (DW'(frame[k]) << (RW * (k - 1)));
          pend = 1'b1;
          frame.delete();
        end
      end else if (frame.size() > 0) begin
        idle++;
        if (TO_EN && idle == TO) begin
          frame.delete();
          idle = 0;
          m_to = 1'b1;
        end
      end
      m_ready = !pend;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [DW*NR-1:0] m_flat;
  int n_strobe = 0, n_err = 0, n_to = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) m_flat[i*DW +: DW] = m_regs[i];
    check ("registers",  registers, m_flat);
    checkv("wr_strobe",  32'(wr_strobe),  32'(m_strobe));
    checkv("addr_error", 32'(addr_error), 32'(m_err));
    checkv("timeout",    32'(timeout),    32'(m_to));
    checkv("wr_addr",    32'(wr_addr),    32'(m_wraddr));
    checkv("rx_ready",   32'(rx_ready),   32'(m_ready));
    if (wr_strobe)  n_strobe++;
    if (addr_error) n_err++;
    if (timeout)    n_to++;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input logic [RW-1:0] w, input int gap, output int stalls);
    bit took;
    int n;
    rx_data = w; rx_valid = 1'b1; took = 1'b0; n = 0; stalls = 0;
    while (!took && n < 50) begin
      took = rx_ready;
      if (!took) stalls++;
      @(negedge clk);
      n++;
    end
    if (!took) begin
      n_checks++; n_fail++;
      $display("FAIL send_accept: word %0h not taken after %0d cycles, required acceptance", w, n);
    end
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int c);
    rx_valid = 1'b0;
    repeat (c) @(negedge clk);
  endtask

  task automatic send_frame(input logic [RW-1:0] a, input logic [DW-1:0] d);
    int s;
    send(a, 0, s);
    send(d[7:0], 0, s);
    send(d[15:8], 0, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s0, e0, t0;
    logic [DW*NR-1:0] exp;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check ("reset registers", registers, 320'h0);
    checkv("reset wr_strobe", 32'(wr_strobe), 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);
    checkv("reset rx_ready", 32'(rx_ready), 32'h1);
    checkv("reset wr_addr", 32'(wr_addr), 32'h0);

    // 1: single frame to register 3, valid held
    s0 = n_strobe;
    send(8'h03, 0, s);
    send(8'h34, 0, s);
    send(8'h12, 0, s);
    checkv("t1 rx_ready low in write cycle", 32'(rx_ready), 32'h0);
    idle_cycles(1);
    checkv("t1 reg3", 32'(registers[63:48]), 32'h1234);
    checkv("t1 wr_addr", 32'(wr_addr), 32'h3);
    check ("t1 all regs", registers, 320'h1234 << 48);
    idle_cycles(1);
    checkv("t1 rx_ready back high", 32'(rx_ready), 32'h1);
    checkv("t1 one strobe", 32'(n_strobe - s0), 32'h1);

    // 2: back-to-back frames to addr 0 and 19
    s0 = n_strobe; e0 = n_err;
    send(8'h00, 0, s); send(8'hEF, 0, s); send(8'hBE, 0, s);
    send(8'h13, 0, s);
    checkv("t2 stall during write cycle", 32'(s), 32'h1);
    send(8'h5A, 0, s); send(8'hA5, 0, s);
    idle_cycles(3);
    checkv("t2 reg0", 32'(registers[15:0]), 32'hBEEF);
    checkv("t2 reg19", 32'(registers[319:304]), 32'hA55A);
    checkv("t2 two strobes", 32'(n_strobe - s0), 32'h2);
    checkv("t2 no addr_error", 32'(n_err - e0), 32'h0);

    // 3: out-of-range address, then a valid frame
    s0 = n_strobe; e0 = n_err;
    exp = 320'h0;
    exp[15:0] = 16'hBEEF; exp[63:48] = 16'h1234; exp[319:304] = 16'hA55A;
    send_frame(8'h14, 16'hFFFF);
    idle_cycles(3);
    checkv("t3 one addr_error", 32'(n_err - e0), 32'h1);
    checkv("t3 no strobe", 32'(n_strobe - s0), 32'h0);
    checkv("t3 wr_addr", 32'(wr_addr), 32'h14);
    check ("t3 regs unchanged", registers, exp);
    send_frame(8'h01, 16'h0002);
    idle_cycles(2);
    checkv("t3 reg1", 32'(registers[31:16]), 32'h0002);

    // 4: random gaps, then an address presented during the write cycle
    send(8'h05, $urandom_range(1, 4), s);
    send(8'hCD, $urandom_range(1, 4), s);
    send(8'hAB, 0, s);
    send(8'h08, 0, s);
    checkv("t4 next addr waits one cycle", 32'(s), 32'h1);
    checkv("t4 reg5", 32'(registers[95:80]), 32'hABCD);
    send(8'h11, $urandom_range(0, 3), s);
    send(8'h22, 0, s);
    idle_cycles(2);
    checkv("t4 reg8", 32'(registers[143:128]), 32'h2211);

    // 5: reset mid-frame
    s0 = n_strobe;
    send(8'h07, 0, s);
    send(8'h11, 0, s);
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check("t5 regs cleared in reset", registers, 320'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkv("t5 no strobe", 32'(n_strobe - s0), 32'h0);
    send_frame(8'h07, 16'h3322);
    idle_cycles(2);
    check ("t5 only reg7", registers, 320'h3322 << 112);

    // 6: idle gap inside a frame
    t0 = n_to;
`ifdef CONF_RX_TIMEOUT_EN
    send(8'h02, 0, s);
    send(8'h44, 0, s);
    idle_cycles(TO + 1);
    checkv("t6 timeout pulse", 32'(n_to - t0), 32'h1);
    checkv("t6 reg2 unchanged", 32'(registers[47:32]), 32'h0);
    send_frame(8'h02, 16'h5566);
    idle_cycles(2);
    checkv("t6 reg2", 32'(registers[47:32]), 32'h5566);
`else
    send(8'h02, 0, s);
    send(8'h44, 0, s);
    idle_cycles(TO + 1);
    checkv("t6 no timeout", 32'(n_to - t0), 32'h0);
    checkv("t6 reg2 not yet written", 32'(registers[47:32]), 32'h0);
    send(8'h55, 0, s);
    idle_cycles(2);
    checkv("t6 reg2", 32'(registers[47:32]), 32'h5544);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
